// File: rtl/ldst_mem_responder.sv
// Data-memory responder for the core's load/store port.
// Word-addressed single-port RAM behind a wait-state FSM (IDLE -> WAIT -> ACK).
// stall_o holds the core while an access is in flight; the ACK cycle releases
// it for exactly one cycle with load data valid on ldst_data_o.
//
// Handshake: the core presents an access in IDLE. stall_o rises in the same
// cycle when the access is new and stays high for LATENCY cycles. The first
// cycle with stall_o low afterwards is ACK: load data is valid and oor_o
// reports a range violation. Inputs are ignored from the cycle after the
// access is accepted until the cycle after ACK.
module ldst_mem_responder #(
    parameter int ADDR       = 32,
    parameter int W_OPR      = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADDR-1:0]  ldst_addr_i,
    input  logic             ldst_write_i,
    input  logic [W_OPR-1:0] ldst_data_i,
    output logic [W_OPR-1:0] ldst_data_o,
    output logic             stall_o,
    output logic             oor_o,
    output logic [1:0]       o_dbg_state
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0]       r_cnt;
    logic [ADDR-1:0]  r_req_addr;
    logic             r_req_write;
    logic [W_OPR-1:0] r_req_data;
    logic             r_req_oor;
    logic [ADDR-1:0]  r_last_addr;
    logic             r_last_write;
    logic             r_last_valid;
    logic [W_OPR-1:0] r_data_out;
    logic [W_OPR-1:0] r_mem [DEPTH];

    logic                  w_new_access;
    logic                  w_commit;
    logic [ADDR-1:0]       w_cmt_addr;
    logic                  w_cmt_write;
    logic [W_OPR-1:0]      w_cmt_data;
    logic                  w_cmt_oor;
    logic [DEPTH_LOG2-1:0] w_cmt_idx;

    // A repeated load of the last loaded address is served from ldst_data_o
    // without a new RAM access; every store is a new access.
    assign w_new_access = (r_state == ST_IDLE) &&
                          (ldst_write_i || !r_last_valid ||
                           (ldst_addr_i != r_last_addr) || r_last_write);

    // With LATENCY=1 the commit happens on the same edge that accepts the
    // access, so the commit operands come straight from the inputs in IDLE.
    assign w_cmt_addr  = (r_state == ST_IDLE) ? ldst_addr_i  : r_req_addr;
    assign w_cmt_write = (r_state == ST_IDLE) ? ldst_write_i : r_req_write;
    assign w_cmt_data  = (r_state == ST_IDLE) ? ldst_data_i  : r_req_data;
    assign w_cmt_oor   = |w_cmt_addr[ADDR-1:DEPTH_LOG2];
    assign w_cmt_idx   = w_cmt_addr[DEPTH_LOG2-1:0];

    // Commit on the edge that enters ACK; a reset on that edge cancels it.
    assign w_commit = !reset && (w_state_nxt == ST_ACK);

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_new_access) w_state_nxt = (LATENCY == 1) ? ST_ACK : ST_WAIT;
            end
            ST_WAIT: begin
                if (r_cnt == 4'd1) w_state_nxt = ST_ACK;
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: stall while pending, release in ACK, reset forces stall low
    always_comb begin
        stall_o     = 1'b0;
        oor_o       = 1'b0;
        o_dbg_state = r_state;
        unique case (r_state)
            ST_IDLE: stall_o = w_new_access;
            ST_WAIT: stall_o = 1'b1;
            ST_ACK:  oor_o   = r_req_oor;
            default: stall_o = 1'b0;
        endcase
        if (reset) begin
            stall_o = 1'b0;
            oor_o   = 1'b0;
        end
    end

    // Wait counter, request capture and last-access tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= 4'd0;
            r_req_addr   <= '0;
            r_req_write  <= 1'b0;
            r_req_data   <= '0;
            r_req_oor    <= 1'b0;
            r_last_addr  <= '0;
            r_last_write <= 1'b0;
            r_last_valid <= 1'b0;
        end else begin
            if (w_new_access) begin
                r_cnt       <= CNT_INIT;
                r_req_addr  <= ldst_addr_i;
                r_req_write <= ldst_write_i;
                r_req_data  <= ldst_data_i;
                r_req_oor   <= |ldst_addr_i[ADDR-1:DEPTH_LOG2];
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == ST_ACK) begin
                r_last_addr  <= r_req_addr;
                r_last_write <= r_req_write;
                r_last_valid <= 1'b1;
            end
        end
    end

    // Load result register: holds until the next load completes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out <= '0;
        end else if (w_commit && !w_cmt_write) begin
            r_data_out <= w_cmt_oor ? '0 : r_mem[w_cmt_idx];
        end
    end

    // RAM write port; contents survive reset, out-of-range stores are dropped
    always_ff @(posedge clk) begin
        if (w_commit && w_cmt_write && !w_cmt_oor) begin
            r_mem[w_cmt_idx] <= w_cmt_data;
        end
    end

    assign ldst_data_o = r_data_out;

endmodule

// File: tb/tb_ldst_mem_responder.sv
// Bench for ldst_mem_responder: three instances with LATENCY 1, 2 and 15
// share the input bus; the one under test runs while the others sit in reset.
// A transaction-level model (word array + last-access record) predicts stall
// width, oor_o and load data for every access.
module tb_ldst_mem_responder;

    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic [31:0] addr_in;
    logic        write_in;
    logic [31:0] data_in;
    logic [2:0]  stall_a;
    logic [2:0]  oor_a;
    logic [31:0] dout_a [3];
    logic [1:0]  dbg_a  [3];
    int          sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the selected instance
    logic [31:0] m_mem   [1024];
    bit          m_known [1024];
    logic [31:0] m_dout;
    bit          m_dout_known;
    bit          m_lv;
    logic [31:0] m_la;
    bit          m_lw;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ldst_mem_responder #(
            .ADDR(32), .W_OPR(32), .DEPTH_LOG2(10),
            .LATENCY((g == 0) ? 1 : ((g == 1) ? 2 : 15))
        ) u_dut (
            .clk         (clk),
            .reset       (rst[g]),
            .ldst_addr_i (addr_in),
            .ldst_write_i(write_in),
            .ldst_data_i (data_in),
            .ldst_data_o (dout_a[g]),
            .stall_o     (stall_a[g]),
            .oor_o       (oor_a[g]),
            .o_dbg_state (dbg_a[g])
        );
    end

    function automatic int cur_lat();
        return (sel == 0) ? 1 : ((sel == 1) ? 2 : 15);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s lat=%0d got=%h exp=%h", tag, cur_lat(), got, exp);
        end
    endtask

    task automatic model_reset();
        m_lv         = 1'b0;
        m_la         = '0;
        m_lw         = 1'b0;
        m_dout       = '0;
        m_dout_known = 1'b1;
    endtask

    // Called at the drive point (#1 after a rising edge). Returns at the
    // drive point of the cycle after the access (or non-access) completes.
    task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d);
        bit       nw;
        bit       oor;
        int       exp_stall;
        int       cnt;
        int       idx;
        addr_in  = a;
        write_in = w;
        data_in  = d;
        nw  = w || !m_lv || (a != m_la) || m_lw;
        oor = (a[31:10] != 22'd0);
        idx = int'(a[9:0]);
        exp_stall = 0;
        if (nw) begin
            exp_stall = cur_lat();
            if (!w) begin
                if (oor) begin
                    m_dout       = '0;
                    m_dout_known = 1'b1;
                end else begin
                    m_dout       = m_mem[idx];
                    m_dout_known = m_known[idx];
                end
            end else if (!oor) begin
                m_mem[idx]   = d;
                m_known[idx] = 1'b1;
            end
            m_lv = 1'b1;
            m_la = a;
            m_lw = w;
        end
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (stall_a[sel]) cnt++;
            else break;
        end
        check_eq("stall_cycles", 32'(cnt), 32'(exp_stall));
        check_eq("oor", 32'(oor_a[sel]), 32'(nw && oor));
        if (m_dout_known) check_eq("load_data", dout_a[sel], m_dout);
        @(posedge clk); #1;
    endtask

    // Put instance s under test from a reset state; returns at a drive point
    task automatic select_dut(input int s);
        sel      = s;
        rst      = 3'b111;
        addr_in  = 32'h0;
        write_in = 1'b1;
        data_in  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_stall", 32'(stall_a[sel]), 32'd0);
        check_eq("rst_oor", 32'(oor_a[sel]), 32'd0);
        check_eq("rst_data", dout_a[sel], 32'd0);
        check_eq("rst_state", 32'(dbg_a[sel]), 32'd0);
        @(posedge clk); #1;
        rst[s]   = 1'b0;
        write_in = 1'b0;
        model_reset();
        for (int i = 0; i < 1024; i++) m_known[i] = 1'b0;
    endtask

    // Store to addr 3, then reset during the first wait cycle
    task automatic reset_mid_store();
        addr_in  = 32'h3;
        write_in = 1'b1;
        data_in  = 32'hA5A5A5A5;
        @(negedge clk);
        check_eq("mid_stall_accept", 32'(stall_a[sel]), 32'd1);
        @(posedge clk); #1;
        rst[sel] = 1'b1;
        @(negedge clk);
        check_eq("mid_stall_rst", 32'(stall_a[sel]), 32'd0);
        @(posedge clk); #1;
        rst[sel] = 1'b0;
        write_in = 1'b0;
        model_reset();
        access(32'h3, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic        w;
        int          r;
        rst      = 3'b111;
        addr_in  = '0;
        write_in = 1'b0;
        data_in  = '0;
        sel      = 0;
        for (int s = 0; s < 3; s++) begin
            select_dut(s);
            // first load after reset: stall width only, RAM content is undefined
            access(32'h5, 1'b0, 32'h0);
            for (int i = 0; i < 17; i++) access(32'(i), 1'b1, $urandom);
            access(32'h10, 1'b1, 32'hDEADBEEF);
            access(32'h10, 1'b0, 32'h0);
            repeat (5) access(32'h10, 1'b0, 32'h0);
            access(32'h400, 1'b0, 32'h0);
            access(32'h400, 1'b1, 32'h1234);
            access(32'h0, 1'b0, 32'h0);
            access(32'h7, 1'b1, $urandom);
            access(32'h7, 1'b1, $urandom);
            access(32'h7, 1'b0, 32'h0);
            if (cur_lat() >= 2) reset_mid_store();
            for (int n = 0; n < 60; n++) begin
                r = $urandom_range(0, 9);
                if (r < 3) begin
                    a = m_la;
                    w = 1'b0;
                end else if (r == 3) begin
                    a = $urandom;
                    a[10] = 1'b1;
                    w = 1'($urandom_range(0, 1));
                end else begin
                    a = 32'($urandom_range(0, 16));
                    w = 1'($urandom_range(0, 1));
                end
                access(a, w, $urandom);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
